// File: rtl/sensor_pkg.sv
// -----------------------------------------------------------------------------
// sensor_pkg
// Shared definitions for the sensor front end:
//   - level_state_t      : tank-level consistency FSM states
//   - DEFAULT_* constants : nominal debounce / fault windows at 50 MHz
//   - cnt_width()        : counter width for an N-cycle window (at least 1 bit)
// -----------------------------------------------------------------------------
package sensor_pkg;

  // 1 ms of stable input at 50 MHz before a debounced output may change.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
  // 5 ms of persistent (in)consistency before entering / leaving FAULT.
  localparam int DEFAULT_FAULT_CYCLES    = 250000;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2
  } level_state_t;

  // A counter that only has to reach n-1 needs clog2(n) bits; keep at least
  // one bit so a window of 1 still yields a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_frontend_debounce_cell.sv
// -----------------------------------------------------------------------------
// debounce_cell
// One raw switch input: 2-flop synchronizer followed by a stability counter.
// The debounced output only changes after the synchronized input has differed
// from it on DEBOUNCE_CYCLES consecutive clock edges.
//
// Ports:
//   clock   : system clock
//   reset_n : asynchronous active-low reset (clears everything to 0)
//   raw     : asynchronous, possibly bouncing switch input
//   deb     : registered debounced value
// -----------------------------------------------------------------------------
module debounce_cell
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic deb
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      deb       <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      // Any agreement restarts the window, so the counter never passes
      // CNT_LAST and cannot wrap.
      if (sync2_reg == deb) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        deb     <= sync2_reg;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sensor_frontend.sv
// -----------------------------------------------------------------------------
// sensor_frontend
// Debounces six greenhouse switches and filters the three tank-level floats
// through a consistency FSM (OK / SUSPECT / FAULT). A physically impossible
// level combination (high without mid, or mid without low) freezes the level
// outputs; if it persists the block flags a sensor fault, and it only returns
// to OK after a sustained clean period.
//
// Ports:
//   clock, reset_n          : system clock, asynchronous active-low reset
//   raw_h, raw_m, raw_l     : raw tank float switches (high / mid / low)
//   raw_t, raw_us, raw_ua   : raw temperature / soil / air humidity switches
//   H, M, L                 : filtered tank levels (last consistent values)
//   T, Us, Ua               : debounced climate / soil flags
//   level_err               : 1 while the level FSM is in FAULT
//   levels_valid            : 1 while the level FSM is in OK
// -----------------------------------------------------------------------------
module sensor_frontend
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FAULT_CYCLES    = DEFAULT_FAULT_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_h,
  input  logic raw_m,
  input  logic raw_l,
  input  logic raw_t,
  input  logic raw_us,
  input  logic raw_ua,
  output logic H,
  output logic M,
  output logic L,
  output logic T,
  output logic Us,
  output logic Ua,
  output logic level_err,
  output logic levels_valid
);

  localparam int FCW = cnt_width(FAULT_CYCLES);
  localparam logic [FCW-1:0] FCNT_LAST = FCW'(FAULT_CYCLES - 1);

  // Channel order: 0=h 1=m 2=l 3=t 4=us 5=ua
  logic [5:0] raw_vec;
  logic [5:0] deb_vec;

  assign raw_vec = {raw_ua, raw_us, raw_t, raw_l, raw_m, raw_h};

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_cell
      debounce_cell #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_cell (
        .clock  (clock),
        .reset_n(reset_n),
        .raw    (raw_vec[gi]),
        .deb    (deb_vec[gi])
      );
    end
  endgenerate

  // Climate flags need no filtering beyond the debounce register itself.
  assign T  = deb_vec[3];
  assign Us = deb_vec[4];
  assign Ua = deb_vec[5];

  // ---------------------------------------------------------------------------
  // Level consistency FSM. All three debounced levels are registers updated on
  // the same edge, so the check below always sees a coherent snapshot.
  // ---------------------------------------------------------------------------
  logic [2:0]     deb_lvl;       // {h, m, l}
  logic           inconsistent;
  level_state_t   state_reg, state_next;
  logic [FCW-1:0] cnt_reg, cnt_next;
  logic [2:0]     hml_reg, hml_next;

  assign deb_lvl      = {deb_vec[0], deb_vec[1], deb_vec[2]};
  assign inconsistent = (deb_vec[0] & ~deb_vec[1]) | (deb_vec[1] & ~deb_vec[2]);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hml_next   = hml_reg;
    case (state_reg)
      ST_OK: begin
        if (inconsistent) begin
          state_next = ST_SUSPECT;
          cnt_next   = '0;
        end else begin
          hml_next = deb_lvl;
        end
      end
      ST_SUSPECT: begin
        if (!inconsistent) begin
          state_next = ST_OK;
          cnt_next   = '0;
        end else if (cnt_reg == FCNT_LAST) begin
          state_next = ST_FAULT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + FCW'(1);
        end
      end
      ST_FAULT: begin
        // Recovery needs an unbroken run of consistent cycles.
        if (inconsistent) begin
          cnt_next = '0;
        end else if (cnt_reg == FCNT_LAST) begin
          state_next = ST_OK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + FCW'(1);
        end
      end
      default: begin
        state_next = ST_OK;
        cnt_next   = '0;
      end
    endcase
  end

  // Status flags are registered decodes of the next state so they line up
  // with state_reg, yet read 0 during reset even though the FSM rests in OK.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_OK;
      cnt_reg      <= '0;
      hml_reg      <= 3'b000;
      levels_valid <= 1'b0;
      level_err    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      hml_reg      <= hml_next;
      levels_valid <= (state_next == ST_OK);
      level_err    <= (state_next == ST_FAULT);
    end
  end

  assign H = hml_reg[2];
  assign M = hml_reg[1];
  assign L = hml_reg[0];

endmodule

// File: tb/tb_sensor_frontend.sv
// -----------------------------------------------------------------------------
// tb_sensor_frontend
// Directed scenarios plus randomized switch activity for sensor_frontend with
// DEBOUNCE_CYCLES=4 and FAULT_CYCLES=8. Expected values come from a reference
// model described in terms of sample histories and run lengths.
// -----------------------------------------------------------------------------
module tb_sensor_frontend;

  localparam int D = 4;
  localparam int F = 8;

  logic clock;
  logic reset_n;
  logic raw_h, raw_m, raw_l, raw_t, raw_us, raw_ua;
  logic H, M, L, T, Us, Ua, level_err, levels_valid;

  int vectors;
  int miscompares;

  sensor_frontend #(
    .DEBOUNCE_CYCLES(D),
    .FAULT_CYCLES   (F)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .raw_h       (raw_h),
    .raw_m       (raw_m),
    .raw_l       (raw_l),
    .raw_t       (raw_t),
    .raw_us      (raw_us),
    .raw_ua      (raw_ua),
    .H           (H),
    .M           (M),
    .L           (L),
    .T           (T),
    .Us          (Us),
    .Ua          (Ua),
    .level_err   (level_err),
    .levels_valid(levels_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  //   debounce: a channel flips once the last D synchronized samples (raw
  //             delayed two edges) all disagree with its current value.
  //   levels  : FAULT after F+1 consecutive inconsistent edges, back to OK
  //             after F consecutive consistent edges while in FAULT; any
  //             consistent edge outside FAULT means OK.
  // Channel order: 0=h 1=m 2=l 3=t 4=us 5=ua
  // ---------------------------------------------------------------------------
  bit d1[6];
  bit d2[6];
  bit mdeb[6];
  bit hist[6][$];
  int m_state;          // 0 ok, 1 suspect, 2 fault
  int inc_run, con_run;
  bit m_hml[3];
  bit m_valid, m_err;

  task automatic model_reset();
    for (int ch = 0; ch < 6; ch++) begin
      d1[ch] = 1'b0;
      d2[ch] = 1'b0;
      mdeb[ch] = 1'b0;
      hist[ch].delete();
    end
    m_state = 0;
    inc_run = 0;
    con_run = 0;
    for (int k = 0; k < 3; k++) m_hml[k] = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  function automatic logic [7:0] model_vec();
    return {m_hml[0], m_hml[1], m_hml[2], mdeb[3], mdeb[4], mdeb[5], m_err, m_valid};
  endfunction

  // Advance one clock edge, update the model with what the edge sampled,
  // and return at the following falling edge where outputs are compared.
  task automatic tick();
    bit cur[6];
    bit c;
    bit sv;
    bit all_diff;
    int prev;
    @(posedge clock);
    cur = '{raw_h, raw_m, raw_l, raw_t, raw_us, raw_ua};
    c = !((mdeb[0] && !mdeb[1]) || (mdeb[1] && !mdeb[2]));
    if (c) begin
      con_run++;
      inc_run = 0;
    end else begin
      inc_run++;
      con_run = 0;
    end
    prev = m_state;
    if (m_state == 2) begin
      if (c && con_run == F) m_state = 0;
    end else if (c) begin
      m_state = 0;
    end else if (inc_run >= F + 1) begin
      m_state = 2;
    end else begin
      m_state = 1;
    end
    if (prev == 0 && c) begin
      for (int k = 0; k < 3; k++) m_hml[k] = mdeb[k];
    end
    m_valid = (m_state == 0);
    m_err   = (m_state == 2);
    for (int ch = 0; ch < 6; ch++) begin
      sv = d2[ch];
      d2[ch] = d1[ch];
      d1[ch] = cur[ch];
      hist[ch].push_back(sv);
      if (hist[ch].size() > D) void'(hist[ch].pop_front());
      if (hist[ch].size() == D) begin
        all_diff = 1'b1;
        foreach (hist[ch][i]) if (hist[ch][i] == mdeb[ch]) all_diff = 1'b0;
        if (all_diff) mdeb[ch] = !mdeb[ch];
      end
    end
    @(negedge clock);
  endtask

  function automatic logic [7:0] obs_vec();
    return {H, M, L, T, Us, Ua, level_err, levels_valid};
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [7:0] obs;
    reset_n = 1'b0;
    {raw_h, raw_m, raw_l, raw_t, raw_us, raw_ua} = 6'b0;
    model_reset();
    #23;
    obs = obs_vec();
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 00000000", obs);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    vectors++;
    if (levels_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_valid: levels_valid=%b expected 1", levels_valid);
    end
    obs = obs_vec();
    vectors++;
    if (obs !== model_vec()) begin
      miscompares++;
      $display("FAIL reset_release_model: got %b expected %b", obs, model_vec());
    end
  endtask

  task automatic test_debounce_latency();
    logic exp;
    raw_us = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      exp = (e >= 6);
      vectors++;
      if (Us !== exp) begin
        miscompares++;
        $display("FAIL latency_us edge %0d: Us=%b expected %b", e, Us, exp);
      end
      vectors++;
      if (obs_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL latency_model edge %0d: got %b expected %b", e, obs_vec(), model_vec());
      end
    end
  endtask

  task automatic test_glitch();
    for (int e = 1; e <= 12; e++) begin
      raw_t = (e <= 3);
      tick();
      vectors++;
      if (T !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_t edge %0d: T=%b expected 0", e, T);
      end
    end
    raw_t = 1'b0;
  endtask

  task automatic test_levels_together();
    logic [2:0] exp;
    {raw_h, raw_m, raw_l} = 3'b111;
    for (int e = 1; e <= 10; e++) begin
      tick();
      exp = (e >= 7) ? 3'b111 : 3'b000;
      vectors++;
      if ({H, M, L} !== exp || levels_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL levels_together edge %0d: HML=%b valid=%b expected HML=%b valid=1",
                 e, {H, M, L}, levels_valid, exp);
      end
      vectors++;
      if (obs_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL levels_model edge %0d: got %b expected %b", e, obs_vec(), model_vec());
      end
    end
  endtask

  task automatic test_fault_entry();
    logic ev, ee;
    raw_m = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      tick();
      ev = (e < 7);
      ee = (e >= 15);
      vectors++;
      if ({H, M, L} !== 3'b111 || levels_valid !== ev || level_err !== ee) begin
        miscompares++;
        $display("FAIL fault_entry edge %0d: HML=%b valid=%b err=%b expected HML=111 valid=%b err=%b",
                 e, {H, M, L}, levels_valid, level_err, ev, ee);
      end
      vectors++;
      if (obs_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL fault_entry_model edge %0d: got %b expected %b", e, obs_vec(), model_vec());
      end
    end
  endtask

  task automatic test_fault_recovery();
    logic ev;
    for (int e = 1; e <= 26; e++) begin
      // Debounced mid drops again around the fifth clean FAULT cycle.
      raw_m = !(e >= 5 && e <= 8);
      tick();
      ev = (e >= 22);
      vectors++;
      if ({H, M, L} !== 3'b111 || levels_valid !== ev || level_err !== !ev) begin
        miscompares++;
        $display("FAIL fault_recovery edge %0d: HML=%b valid=%b err=%b expected HML=111 valid=%b err=%b",
                 e, {H, M, L}, levels_valid, level_err, ev, !ev);
      end
      vectors++;
      if (obs_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL fault_recovery_model edge %0d: got %b expected %b", e, obs_vec(), model_vec());
      end
    end
  endtask

  task automatic test_reset_in_fault();
    logic [7:0] obs;
    raw_m = 1'b0;
    for (int e = 1; e <= 16; e++) tick();
    vectors++;
    if (level_err !== 1'b1 || obs_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL refault: got %b expected %b (err=1)", obs_vec(), model_vec());
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    obs = obs_vec();
    vectors++;
    if (obs !== 8'h00) begin
      miscompares++;
      $display("FAIL async_reset: got %b expected 00000000", obs);
    end
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    obs = obs_vec();
    vectors++;
    if (obs !== 8'b0000_0001 || obs !== model_vec()) begin
      miscompares++;
      $display("FAIL reset_after_fault: got %b expected 00000001", obs);
    end
  endtask

  task automatic test_random();
    int hold[6];
    bit val[6];
    {raw_h, raw_m, raw_l, raw_t, raw_us, raw_ua} = 6'b0;
    reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    for (int ch = 0; ch < 6; ch++) begin
      hold[ch] = 0;
      val[ch]  = 1'b0;
    end
    for (int i = 0; i < 800; i++) begin
      for (int ch = 0; ch < 6; ch++) begin
        if (hold[ch] == 0) begin
          val[ch]  = 1'($urandom_range(0, 1));
          hold[ch] = (ch < 3) ? $urandom_range(1, 25) : $urandom_range(1, 8);
        end
        hold[ch]--;
      end
      {raw_h, raw_m, raw_l, raw_t, raw_us, raw_ua} =
        {val[0], val[1], val[2], val[3], val[4], val[5]};
      tick();
      vectors++;
      if (obs_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %b expected %b", i, obs_vec(), model_vec());
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_debounce_latency();
    test_glitch();
    test_levels_together();
    test_fault_entry();
    test_fault_recovery();
    test_reset_in_fault();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
